fp32_div_issue: RTL and testbench
=================================

FP32_DIV_ISSUE -- requirements
Module: fp32_div_issue

Interface
REQ-001 Parameter ITER_CYCLES, default 15, is the number of clk cycles from core launch to a valid core quotient.
REQ-002 Port clk  input  1  rising-edge clock.
REQ-003 Port rst  input  1  reset, asynchronous, active-low.
REQ-004 Port in_valid  input  1  operand pair offered.
REQ-005 Port in_ready  output  1  block accepts operands this cycle.
REQ-006 Port in_dividend  input  32  IEEE-754 single dividend.
REQ-007 Port in_divisor  input  32  IEEE-754 single divisor.
REQ-008 Port core_dividend  output  32  operand to SRT core, held stable during RUN.
REQ-009 Port core_divisor  output  32  operand to SRT core, held stable during RUN.
REQ-010 Port core_rst_n  output  1  active-low restart to SRT core, low exactly one cycle per launch.
REQ-011 Port core_quotient  input  32  packed quotient from SRT core.
REQ-012 Port out_valid  output  1  result available.
REQ-013 Port out_ready  input  1  consumer accepts result.
REQ-014 Port out_result  output  32  IEEE-754 single quotient.
REQ-015 Port out_flags  output  4  {invalid, div_by_zero, denorm_flush, bypass}.

Function
REQ-016 FSM states SHALL be IDLE, LAUNCH, RUN, DONE; in_ready = (state==IDLE).
REQ-017 On in_valid & in_ready, operands SHALL be latched; next state is DONE if a special case applies, else LAUNCH.
REQ-018 Special-case priority SHALL be: any NaN, 0/0, inf/inf -> 0x7FC00000, invalid=1; finite nonzero/0 -> signed inf, div_by_zero=1; inf/finite -> signed inf; finite/inf or 0/nonzero -> signed zero; bypass=1 for all.
REQ-019 Result sign SHALL be dividend sign XOR divisor sign for all non-NaN results.
REQ-020 Subnormal operands (exp=0, frac!=0) SHALL be flushed to signed zero before classification, with denorm_flush=1.
REQ-021 LAUNCH SHALL last one cycle with core_rst_n=0; then RUN with a 5-bit counter cleared to 0.
REQ-022 In RUN the counter SHALL increment each cycle; when counter == ITER_CYCLES-1, core_quotient SHALL be captured into out_result and state SHALL go to DONE.
REQ-023 Non-bypass result latency from accepting handshake to out_valid SHALL be ITER_CYCLES+2 cycles; bypass latency SHALL be 1 cycle.
REQ-024 In DONE, out_valid=1 and out_result/out_flags SHALL hold stable until out_ready=1; handshake returns FSM to IDLE.
REQ-025 in_ready SHALL be 0 in the handshake cycle of DONE (no same-cycle re-accept); next op accepted earliest one cycle later.
REQ-026 core_dividend/core_divisor SHALL change only on input handshake; core_rst_n SHALL be 1 outside LAUNCH.
REQ-027 Input operands are ignored while in_ready=0 regardless of in_valid.

Reset
REQ-028 While rst=0: state=IDLE, in_ready=1 after release, out_valid=0, out_result=0, out_flags=0, counter=0, core_rst_n=0 (core held in reset), core operand registers=0.
REQ-029 Reset asserted mid-RUN or mid-DONE SHALL discard the operation; no out_valid follows release.

Structure
REQ-030 Package fp32_div_pkg SHALL hold the state enum, the fp class typedef (ZERO, SUB, NORM, INF, NAN), QNAN=32'h7FC00000, and the flag bit indices.
REQ-031 One sub-module fp32_classify SHALL map a 32-bit operand to its class (combinational); two instances, one per operand.
REQ-032 Result-select and special-case logic SHALL remain in fp32_div_issue.

Verification
REQ-033 0x40C00000 / 0x40000000, core model returns 0x40400000 -> core_rst_n low 1 cycle, out_valid after 17 cycles, result 0x40400000, flags 0.
REQ-034 0x3F800000 / 0x00000000 -> out_valid after 1 cycle, result 0x7F800000, flags 4'b0101; core_rst_n stays 1.
REQ-035 0x7FC00001 / 0x3F800000 and 0x00000000 / 0x80000000 -> 0x7FC00000 flags 4'b1001 each.
REQ-036 0x00000001 / 0xBF800000 -> result 0x80000000, flags 4'b0011.
REQ-037 Hold out_ready=0 for 10 cycles after out_valid -> result/flags stable, in_ready=0; in_valid pulses meanwhile are not accepted.
REQ-038 Assert rst at RUN counter=5 -> all outputs at reset values; no out_valid after release; next op completes normally.

Source files
------------

// File: rtl/fp32_div_pkg.sv
// Shared types and constants for the fp32 divide issue stage.
// Holds FSM states, operand classes, the canonical quiet NaN and flag bit positions.
package fp32_div_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_LAUNCH,
    ST_RUN,
    ST_DONE
  } state_e;

  typedef enum logic [2:0] {
    FP_ZERO,
    FP_SUB,
    FP_NORM,
    FP_INF,
    FP_NAN
  } fp_class_e;

  localparam logic [31:0] QNAN = 32'h7FC00000;

  // Bit positions within out_flags = {invalid, div_by_zero, denorm_flush, bypass}
  localparam int FLAG_INVALID  = 3;
  localparam int FLAG_DIV_ZERO = 2;
  localparam int FLAG_DENORM   = 1;
  localparam int FLAG_BYPASS   = 0;

endpackage

// File: rtl/fp32_classify.sv
// Combinational IEEE-754 single classifier: zero / subnormal / normal / inf / NaN.
// Sign is passed through separately so callers need not re-slice the operand.
module fp32_classify
  import fp32_div_pkg::*;
(
  input  logic [31:0] op_i,
  output fp_class_e   class_o,
  output logic        sign_o
);

  logic [7:0]  exp_w;
  logic [22:0] frac_w;

  assign sign_o = op_i[31];
  assign exp_w  = op_i[30:23];
  assign frac_w = op_i[22:0];

  always_comb begin
    class_o = FP_NORM;
    if (exp_w == 8'h00) begin
      class_o = (frac_w == 23'h0) ? FP_ZERO : FP_SUB;
    end else if (exp_w == 8'hFF) begin
      class_o = (frac_w == 23'h0) ? FP_INF : FP_NAN;
    end
  end

endmodule

// File: rtl/fp32_div_issue.sv
// Issue/result stage around an iterative SRT divider: resolves special cases locally,
// otherwise restarts the core for one cycle and captures its quotient ITER_CYCLES later.
module fp32_div_issue
  import fp32_div_pkg::*;
#(
  parameter int ITER_CYCLES = 15
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] in_dividend,
  input  logic [31:0] in_divisor,
  output logic [31:0] core_dividend,
  output logic [31:0] core_divisor,
  output logic        core_rst_n,
  input  logic [31:0] core_quotient,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_result,
  output logic [3:0]  out_flags
);

  localparam logic [4:0] ITER_LAST = 5'(ITER_CYCLES - 1);

  state_e      state_q, state_d;
  logic [4:0]  cnt_q, cnt_d;
  logic [31:0] dvd_q, dvs_q, res_q;
  logic [3:0]  flags_q;
  logic        core_rst_n_q;

  fp_class_e   cls_a, cls_b, eff_a, eff_b;
  logic        sign_a, sign_b, res_sign;
  logic        special;
  logic [31:0] spc_res;
  logic [3:0]  spc_flags;
  logic        accept;

  fp32_classify u_cls_dividend (.op_i(in_dividend), .class_o(cls_a), .sign_o(sign_a));
  fp32_classify u_cls_divisor  (.op_i(in_divisor),  .class_o(cls_b), .sign_o(sign_b));

  assign accept = in_valid & in_ready;

  // Subnormals are treated as zero of the same sign before the priority chain.
  always_comb begin
    eff_a     = (cls_a == FP_SUB) ? FP_ZERO : cls_a;
    eff_b     = (cls_b == FP_SUB) ? FP_ZERO : cls_b;
    res_sign  = sign_a ^ sign_b;
    special   = 1'b1;
    spc_res   = 32'h0;
    spc_flags = 4'h0;
    if (eff_a == FP_NAN || eff_b == FP_NAN ||
        (eff_a == FP_ZERO && eff_b == FP_ZERO) ||
        (eff_a == FP_INF && eff_b == FP_INF)) begin
      spc_res                 = QNAN;
      spc_flags[FLAG_INVALID] = 1'b1;
    end else if (eff_b == FP_ZERO) begin
      spc_res                  = {res_sign, 8'hFF, 23'h0};
      spc_flags[FLAG_DIV_ZERO] = 1'b1;
    end else if (eff_a == FP_INF) begin
      spc_res = {res_sign, 8'hFF, 23'h0};
    end else if (eff_b == FP_INF || eff_a == FP_ZERO) begin
      spc_res = {res_sign, 31'h0};
    end else begin
      special = 1'b0;
    end
    spc_flags[FLAG_BYPASS] = special;
    spc_flags[FLAG_DENORM] = (cls_a == FP_SUB) || (cls_b == FP_SUB);
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      ST_IDLE: begin
        if (accept) state_d = special ? ST_DONE : ST_LAUNCH;
      end
      ST_LAUNCH: begin
        state_d = ST_RUN;
        cnt_d   = 5'd0;
      end
      ST_RUN: begin
        cnt_d = cnt_q + 5'd1;
        if (cnt_q == ITER_LAST) state_d = ST_DONE;
      end
      ST_DONE: begin
        cnt_d = 5'd0;
        if (out_ready) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= ST_IDLE;
      cnt_q        <= 5'd0;
      dvd_q        <= 32'h0;
      dvs_q        <= 32'h0;
      res_q        <= 32'h0;
      flags_q      <= 4'h0;
      core_rst_n_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      // Registered so the restart pulse is exactly the LAUNCH cycle.
      core_rst_n_q <= (state_d != ST_LAUNCH);
      if (accept) begin
        dvd_q   <= in_dividend;
        dvs_q   <= in_divisor;
        res_q   <= spc_res;
        flags_q <= spc_flags;
      end else if (state_q == ST_RUN && cnt_q == ITER_LAST) begin
        res_q   <= core_quotient;
        flags_q <= 4'h0;
      end
    end
  end

  assign in_ready      = (state_q == ST_IDLE);
  assign out_valid     = (state_q == ST_DONE);
  assign out_result    = res_q;
  assign out_flags     = flags_q;
  assign core_dividend = dvd_q;
  assign core_divisor  = dvs_q;
  assign core_rst_n    = core_rst_n_q;

endmodule

// File: tb/tb_fp32_div_issue.sv
// Directed bench for fp32_div_issue with a timing-aware SRT core stand-in.
module tb_fp32_div_issue;

  localparam int ITER = 15;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_dividend;
  logic [31:0] in_divisor;
  logic [31:0] core_dividend;
  logic [31:0] core_divisor;
  logic        core_rst_n;
  logic [31:0] core_quotient;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_result;
  logic [3:0]  out_flags;

  int checks = 0;
  int errors = 0;
  int core_k = 0;

  fp32_div_issue #(.ITER_CYCLES(ITER)) dut (
    .clk           (clk),
    .rst           (rst),
    .in_valid      (in_valid),
    .in_ready      (in_ready),
    .in_dividend   (in_dividend),
    .in_divisor    (in_divisor),
    .core_dividend (core_dividend),
    .core_divisor  (core_divisor),
    .core_rst_n    (core_rst_n),
    .core_quotient (core_quotient),
    .out_valid     (out_valid),
    .out_ready     (out_ready),
    .out_result    (out_result),
    .out_flags     (out_flags)
  );

  always #5 clk = ~clk;

  // Core stand-in: quotient only becomes correct after ITER-1 cycles out of restart.
  always @(posedge clk) begin
    if (!core_rst_n) core_k <= 0;
    else if (core_k < 31) core_k <= core_k + 1;
  end

  function automatic logic [31:0] core_table(input logic [31:0] a, input logic [31:0] b);
    if (a == 32'h40C00000 && b == 32'h40000000) return 32'h40400000;
    if (a == 32'h42280000 && b == 32'h40C00000) return 32'h40E00000;
    return 32'hFFFFFFFF;
  endfunction

  assign core_quotient = (core_k >= ITER - 1) ? core_table(core_dividend, core_divisor)
                                              : 32'hBAD0BAD0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic run_op(input logic [31:0] a, input logic [31:0] b, input int exp_lat,
                        input logic [31:0] exp_res, input logic [3:0] exp_flags,
                        input int exp_low, input int hold);
    int lat;
    int low;
    @(negedge clk);
    in_valid    = 1'b1;
    in_dividend = a;
    in_divisor  = b;
    check("in_ready_idle", 32'(in_ready), 32'd1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    lat = 1;
    low = 0;
    while (!out_valid && lat < 40) begin
      if (!core_rst_n) low++;
      @(posedge clk); #1;
      lat++;
    end
    check("latency", 32'(lat), 32'(exp_lat));
    check("core_rst_low_cycles", 32'(low), 32'(exp_low));
    check("result", out_result, exp_res);
    check("flags", 32'(out_flags), 32'(exp_flags));
    check("core_dividend", core_dividend, a);
    check("core_divisor", core_divisor, b);
    check("core_rst_n_done", 32'(core_rst_n), 32'd1);
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      in_valid    = 1'b1;
      in_dividend = 32'h3F800000;
      in_divisor  = 32'h3F800000;
      @(posedge clk); #1;
      check("hold_valid", 32'(out_valid), 32'd1);
      check("hold_result", out_result, exp_res);
      check("hold_flags", 32'(out_flags), 32'(exp_flags));
      check("hold_in_ready", 32'(in_ready), 32'd0);
      check("hold_core_dividend", core_dividend, a);
    end
    @(negedge clk);
    in_valid  = 1'b0;
    out_ready = 1'b1;
    check("in_ready_out_hs", 32'(in_ready), 32'd0);
    @(posedge clk); #1;
    out_ready = 1'b0;
    check("valid_after_hs", 32'(out_valid), 32'd0);
    check("in_ready_after_hs", 32'(in_ready), 32'd1);
  endtask

  initial begin
    int seen;
    rst         = 1'b0;
    in_valid    = 1'b0;
    out_ready   = 1'b0;
    in_dividend = 32'h0;
    in_divisor  = 32'h0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_in_ready", 32'(in_ready), 32'd1);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_out_result", out_result, 32'h0);
    check("rst_out_flags", 32'(out_flags), 32'd0);
    check("rst_core_rst_n", 32'(core_rst_n), 32'd0);
    check("rst_core_dividend", core_dividend, 32'h0);
    check("rst_core_divisor", core_divisor, 32'h0);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk); #1;

    run_op(32'h40C00000, 32'h40000000, ITER + 2, 32'h40400000, 4'b0000, 1, 0);
    run_op(32'h3F800000, 32'h00000000, 1, 32'h7F800000, 4'b0101, 0, 0);
    run_op(32'h7FC00001, 32'h3F800000, 1, 32'h7FC00000, 4'b1001, 0, 0);
    run_op(32'h00000000, 32'h80000000, 1, 32'h7FC00000, 4'b1001, 0, 0);
    run_op(32'h7F800000, 32'hC0000000, 1, 32'hFF800000, 4'b0001, 0, 0);
    run_op(32'h40000000, 32'hFF800000, 1, 32'h80000000, 4'b0001, 0, 0);
    run_op(32'h7F800000, 32'hFF800000, 1, 32'h7FC00000, 4'b1001, 0, 0);
    run_op(32'h00000001, 32'hBF800000, 1, 32'h80000000, 4'b0011, 0, 10);

    // Abort an operation with reset while the run counter is at 5.
    @(negedge clk);
    in_valid    = 1'b1;
    in_dividend = 32'h42280000;
    in_divisor  = 32'h40C00000;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (6) @(posedge clk);
    #1;
    rst = 1'b0;
    #1;
    check("midrun_out_valid", 32'(out_valid), 32'd0);
    check("midrun_in_ready", 32'(in_ready), 32'd1);
    check("midrun_out_result", out_result, 32'h0);
    check("midrun_out_flags", 32'(out_flags), 32'd0);
    check("midrun_core_rst_n", 32'(core_rst_n), 32'd0);
    check("midrun_core_dividend", core_dividend, 32'h0);
    check("midrun_core_divisor", core_divisor, 32'h0);
    @(negedge clk);
    rst = 1'b1;
    seen = 0;
    for (int i = 0; i < 25; i++) begin
      @(posedge clk); #1;
      if (out_valid) seen = 1;
    end
    check("no_valid_after_abort", 32'(seen), 32'd0);

    run_op(32'h42280000, 32'h40C00000, ITER + 2, 32'h40E00000, 4'b0000, 1, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
